// File: rtl/crc_stream.sv
// Streaming CRC engine with run-time width, polynomial, init, xorout and reflection.
// Consumes up to DATA_INP_WD/8 bytes per beat and presents one result per frame.
module crc_stream #(
    parameter int DATA_INP_WD = 32,
    parameter int DATA_OUT_WD = 32,
    localparam int BYTE_NUM    = DATA_INP_WD / 8,
    localparam int SIZE_OUT_WD = $clog2(DATA_OUT_WD),
    localparam int NUM_WD      = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SIZE_OUT_WD-1:0] cfg_siz_poly_i,
    input  logic [DATA_OUT_WD-1:0] cfg_dat_poly_i,
    input  logic [DATA_OUT_WD-1:0] cfg_dat_init_i,
    input  logic [DATA_OUT_WD-1:0] cfg_dat_xorout_i,
    input  logic                   cfg_flg_refin_i,
    input  logic                   cfg_flg_refout_i,
    input  logic                   val_i,
    output logic                   rdy_o,
    input  logic                   flg_fst_i,
    input  logic                   flg_lst_i,
    input  logic [DATA_INP_WD-1:0] dat_i,
    input  logic [NUM_WD-1:0]      num_i,
    output logic                   val_o,
    input  logic                   rdy_i,
    output logic [DATA_OUT_WD-1:0] dat_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // The init value is consumed on the first beat itself, so only the fields
    // needed for later beats and for output formatting are kept.
    typedef struct packed {
        logic [SIZE_OUT_WD-1:0] siz;
        logic [DATA_OUT_WD-1:0] poly;
        logic [DATA_OUT_WD-1:0] xorout;
        logic                   refin;
        logic                   refout;
    } cfg_t;

    state_t                 state_q, state_d;
    cfg_t                   cfg_q, cfg_d;
    logic [DATA_OUT_WD-1:0] crc_q, crc_d;
    logic [DATA_OUT_WD-1:0] dat_q, dat_d;
    logic                   err_q, err_d;

    cfg_t                   cfg_in;
    cfg_t                   beat_cfg;
    logic [DATA_OUT_WD-1:0] beat_start;
    logic [DATA_OUT_WD-1:0] beat_crc;
    logic [NUM_WD-1:0]      beat_last_idx;
    logic                   beat_acc;

    function automatic logic [DATA_OUT_WD-1:0] width_mask(input logic [SIZE_OUT_WD-1:0] siz);
        logic [DATA_OUT_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_OUT_WD; i++) begin
            if (i <= int'(siz)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Full-width reversal, then shift down so the W-bit result is right-aligned.
    function automatic logic [DATA_OUT_WD-1:0] reflect_w(input logic [DATA_OUT_WD-1:0] c,
                                                         input logic [SIZE_OUT_WD-1:0] siz);
        logic [DATA_OUT_WD-1:0] r;
        for (int i = 0; i < DATA_OUT_WD; i++) r[i] = c[DATA_OUT_WD-1-i];
        return r >> (DATA_OUT_WD - 1 - int'(siz));
    endfunction

    function automatic logic [DATA_OUT_WD-1:0] crc_byte(input logic [DATA_OUT_WD-1:0] crc_in,
                                                        input logic [7:0]             b,
                                                        input logic [DATA_OUT_WD-1:0] poly,
                                                        input logic [SIZE_OUT_WD-1:0] siz);
        logic [DATA_OUT_WD-1:0] c;
        logic [DATA_OUT_WD-1:0] m;
        logic [DATA_OUT_WD-1:0] top;
        logic                   fb;
        c   = crc_in;
        m   = width_mask(siz);
        top = DATA_OUT_WD'(1) << siz;
        for (int i = 7; i >= 0; i--) begin
            fb = (|(c & top)) ^ b[i];
            c  = (c << 1) & m;
            if (fb) c = c ^ (poly & m);
        end
        return c;
    endfunction

    function automatic logic [DATA_OUT_WD-1:0] crc_beat(input logic [DATA_OUT_WD-1:0] start,
                                                        input logic [DATA_INP_WD-1:0] data,
                                                        input logic [NUM_WD-1:0]      last_idx,
                                                        input cfg_t                   cfg);
        logic [DATA_OUT_WD-1:0] c;
        logic [7:0]             b;
        c = start;
        for (int k = 0; k < BYTE_NUM; k++) begin
            b = data[8*k +: 8];
            if (cfg.refin) b = reflect8(b);
            if (k <= int'(last_idx)) c = crc_byte(c, b, cfg.poly, cfg.siz);
        end
        return c;
    endfunction

    function automatic logic [DATA_OUT_WD-1:0] crc_format(input logic [DATA_OUT_WD-1:0] c,
                                                          input cfg_t                   cfg);
        logic [DATA_OUT_WD-1:0] r;
        r = cfg.refout ? reflect_w(c, cfg.siz) : c;
        return (r ^ cfg.xorout) & width_mask(cfg.siz);
    endfunction

    assign rdy_o = (state_q != ST_DONE);
    assign val_o = (state_q == ST_DONE);
    assign dat_o = dat_q;
    assign err_o = err_q;

    always_comb begin
        cfg_in.siz    = cfg_siz_poly_i;
        cfg_in.poly   = cfg_dat_poly_i;
        cfg_in.xorout = cfg_dat_xorout_i;
        cfg_in.refin  = cfg_flg_refin_i;
        cfg_in.refout = cfg_flg_refout_i;

        // A first beat always restarts from the live configuration and init value.
        beat_cfg      = flg_fst_i ? cfg_in : cfg_q;
        beat_start    = flg_fst_i ? (cfg_dat_init_i & width_mask(cfg_siz_poly_i)) : crc_q;
        beat_last_idx = flg_lst_i ? num_i : NUM_WD'(BYTE_NUM - 1);
        beat_crc      = crc_beat(beat_start, dat_i, beat_last_idx, beat_cfg);
        beat_acc      = val_i && rdy_o;
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cfg_d   = cfg_q;
        crc_d   = crc_q;
        dat_d   = dat_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_BUSY: begin
                if (beat_acc) begin
                    if (state_q == ST_IDLE && !flg_fst_i) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = (state_q == ST_BUSY) && flg_fst_i;
                        cfg_d = beat_cfg;
                        crc_d = beat_crc;
                        if (flg_lst_i) begin
                            state_d = ST_DONE;
                            dat_d   = crc_format(beat_crc, beat_cfg);
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (rdy_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            crc_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            crc_q   <= crc_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_crc_stream.sv
// Directed bench for crc_stream: catalogue CRCs of "123456789", backpressure,
// protocol errors, partial last beats and reset in mid-frame and in DONE.
module tb_crc_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cfg_siz_poly_i;
    logic [31:0] cfg_dat_poly_i;
    logic [31:0] cfg_dat_init_i;
    logic [31:0] cfg_dat_xorout_i;
    logic        cfg_flg_refin_i;
    logic        cfg_flg_refout_i;
    logic        val_i;
    logic        rdy_o;
    logic        flg_fst_i;
    logic        flg_lst_i;
    logic [31:0] dat_i;
    logic [1:0]  num_i;
    logic        val_o;
    logic        rdy_i;
    logic [31:0] dat_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    crc_stream #(.DATA_INP_WD(32), .DATA_OUT_WD(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_siz_poly_i   (cfg_siz_poly_i),
        .cfg_dat_poly_i   (cfg_dat_poly_i),
        .cfg_dat_init_i   (cfg_dat_init_i),
        .cfg_dat_xorout_i (cfg_dat_xorout_i),
        .cfg_flg_refin_i  (cfg_flg_refin_i),
        .cfg_flg_refout_i (cfg_flg_refout_i),
        .val_i            (val_i),
        .rdy_o            (rdy_o),
        .flg_fst_i        (flg_fst_i),
        .flg_lst_i        (flg_lst_i),
        .dat_i            (dat_i),
        .num_i            (num_i),
        .val_o            (val_o),
        .rdy_i            (rdy_i),
        .dat_o            (dat_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [4:0] siz, input logic [31:0] poly, input logic [31:0] init,
                           input logic [31:0] xorout, input logic refin, input logic refout);
        cfg_siz_poly_i   = siz;
        cfg_dat_poly_i   = poly;
        cfg_dat_init_i   = init;
        cfg_dat_xorout_i = xorout;
        cfg_flg_refin_i  = refin;
        cfg_flg_refout_i = refout;
    endtask

    task automatic cfg_crc32();  set_cfg(5'd31, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1); endtask
    task automatic cfg_crc16();  set_cfg(5'd15, 32'h00001021, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b0); endtask
    task automatic cfg_crc8();   set_cfg(5'd7,  32'h00000007, 32'h00000000, 32'h00000000, 1'b0, 1'b0); endtask

    task automatic beat(input logic fst, input logic lst, input logic [31:0] data, input logic [1:0] num);
        val_i     = 1'b1;
        flg_fst_i = fst;
        flg_lst_i = lst;
        dat_i     = data;
        num_i     = num;
        step();
        val_i     = 1'b0;
        flg_fst_i = 1'b0;
        flg_lst_i = 1'b0;
        dat_i     = '0;
        num_i     = '0;
    endtask

    // "123456789" in three beats; upper bytes of the final beat are junk.
    task automatic frame_123456789(input logic [31:0] last_beat);
        beat(1'b1, 1'b0, 32'h34333231, 2'd0);
        beat(1'b0, 1'b0, 32'h38373635, 2'd0);
        beat(1'b0, 1'b1, last_beat,    2'd0);
    endtask

    task automatic consume(input string tag);
        rdy_i = 1'b1;
        step();
        rdy_i = 1'b0;
        check({tag, "_val_after_consume"}, {31'd0, val_o}, 32'd0);
        check({tag, "_rdy_after_consume"}, {31'd0, rdy_o}, 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        val_i = 1'b0; flg_fst_i = 1'b0; flg_lst_i = 1'b0;
        dat_i = '0;   num_i = '0;       rdy_i = 1'b0;
        cfg_crc32();
        step();
        step();
        rst = 1'b0;
        check("reset_val", {31'd0, val_o}, 32'd0);
        check("reset_err", {31'd0, err_o}, 32'd0);
        check("reset_dat", dat_o,          32'd0);
        check("reset_rdy", {31'd0, rdy_o}, 32'd1);

        // CRC-32 check value, then hold the result under backpressure.
        cfg_crc32();
        frame_123456789(32'h00000039);
        check("crc32_val", {31'd0, val_o}, 32'd1);
        check("crc32_dat", dat_o,          32'hCBF43926);
        check("crc32_rdy", {31'd0, rdy_o}, 32'd0);
        val_i = 1'b1; flg_fst_i = 1'b1; flg_lst_i = 1'b1; dat_i = 32'h000000AA;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_val", {31'd0, val_o}, 32'd1);
            check("hold_dat", dat_o,          32'hCBF43926);
            check("hold_rdy", {31'd0, rdy_o}, 32'd0);
            check("hold_err", {31'd0, err_o}, 32'd0);
        end
        val_i = 1'b0; flg_fst_i = 1'b0; flg_lst_i = 1'b0; dat_i = '0;
        consume("crc32");

        // CRC-16/CCITT-FALSE with junk upper bytes and a mid-frame cfg change.
        cfg_crc16();
        beat(1'b1, 1'b0, 32'h34333231, 2'd0);
        set_cfg(5'd7, 32'h00000007, 32'h00000000, 32'h000000FF, 1'b1, 1'b1);
        beat(1'b0, 1'b0, 32'h38373635, 2'd0);
        beat(1'b0, 1'b1, 32'hDEADBE39, 2'd0);
        check("crc16_val", {31'd0, val_o}, 32'd1);
        check("crc16_dat", dat_o,          32'h000029B1);
        consume("crc16");

        // CRC-8 full frame, then single-beat frames with 1 and 2 valid bytes.
        cfg_crc8();
        frame_123456789(32'h00000039);
        check("crc8_dat", dat_o, 32'h000000F4);
        consume("crc8");
        beat(1'b1, 1'b1, 32'hFFFFFF31, 2'd0);
        check("crc8_1byte_val", {31'd0, val_o}, 32'd1);
        check("crc8_1byte_dat", dat_o,          32'h00000097);
        check("crc8_1byte_err", {31'd0, err_o}, 32'd0);
        consume("crc8_1byte");
        beat(1'b1, 1'b1, 32'hFFFF3231, 2'd1);
        check("crc8_2byte_dat", dat_o, 32'h00000072);
        consume("crc8_2byte");

        // Non-first beat while idle is dropped with an error pulse.
        beat(1'b0, 1'b1, 32'h12345678, 2'd3);
        check("idle_err",      {31'd0, err_o}, 32'd1);
        check("idle_err_val",  {31'd0, val_o}, 32'd0);
        check("idle_err_rdy",  {31'd0, rdy_o}, 32'd1);
        step();
        check("idle_err_pulse", {31'd0, err_o}, 32'd0);
        check("idle_stay_val",  {31'd0, val_o}, 32'd0);

        // First beat mid-frame aborts and restarts with the new configuration.
        cfg_crc32();
        beat(1'b1, 1'b0, 32'h11223344, 2'd0);
        cfg_crc16();
        beat(1'b1, 1'b0, 32'h34333231, 2'd0);
        check("abort_err", {31'd0, err_o}, 32'd1);
        beat(1'b0, 1'b0, 32'h38373635, 2'd0);
        check("abort_err_pulse", {31'd0, err_o}, 32'd0);
        beat(1'b0, 1'b1, 32'h00000039, 2'd0);
        check("abort_val", {31'd0, val_o}, 32'd1);
        check("abort_dat", dat_o,          32'h000029B1);
        consume("abort");

        // Reset mid-frame, with a competing fst+lst beat in the reset cycle.
        cfg_crc32();
        beat(1'b1, 1'b0, 32'h34333231, 2'd0);
        rst = 1'b1;
        val_i = 1'b1; flg_fst_i = 1'b1; flg_lst_i = 1'b1; dat_i = 32'h00000031;
        step();
        rst = 1'b0;
        val_i = 1'b0; flg_fst_i = 1'b0; flg_lst_i = 1'b0; dat_i = '0;
        check("rst_mid_val", {31'd0, val_o}, 32'd0);
        check("rst_mid_err", {31'd0, err_o}, 32'd0);
        check("rst_mid_dat", dat_o,          32'd0);
        check("rst_mid_rdy", {31'd0, rdy_o}, 32'd1);
        step();
        check("rst_mid_still_idle", {31'd0, val_o}, 32'd0);

        // Reset while a result is pending.
        cfg_crc8();
        frame_123456789(32'h00000039);
        check("pre_rst_done_val", {31'd0, val_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_done_val", {31'd0, val_o}, 32'd0);
        check("rst_done_err", {31'd0, err_o}, 32'd0);
        check("rst_done_dat", dat_o,          32'd0);
        check("rst_done_rdy", {31'd0, rdy_o}, 32'd1);

        // Clean frame after reset.
        cfg_crc32();
        frame_123456789(32'h55AA0039);
        check("post_rst_val", {31'd0, val_o}, 32'd1);
        check("post_rst_dat", dat_o,          32'hCBF43926);
        consume("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 The block SHALL have parameter DATA_INP_WD, default 32, giving the input beat width in bits (multiple of 8, 8..64).
REQ-002 The block SHALL have parameter DATA_OUT_WD, default 32, giving the maximum CRC width in bits (8..64).
REQ-003 The block SHALL derive BYTE_NUM = DATA_INP_WD/8 and SIZE_OUT_WD = log2(DATA_OUT_WD).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, the clock.
REQ-006 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-007 The block SHALL have port cfg_siz_poly_i, input, SIZE_OUT_WD, giving CRC width minus 1 (W = value+1).
REQ-008 The block SHALL have ports cfg_dat_poly_i, cfg_dat_init_i and cfg_dat_xorout_i, input, DATA_OUT_WD, holding the polynomial without the top bit, the initial value and the final XOR, right-aligned.
REQ-009 The block SHALL have ports cfg_flg_refin_i and cfg_flg_refout_i, input, 1, selecting input byte reflection and output reflection.
REQ-010 The block SHALL have ports val_i (input, 1, beat valid), rdy_o (output, 1, beat accepted when val_i&&rdy_o), flg_fst_i and flg_lst_i (input, 1, first and last beat of frame).
REQ-011 The block SHALL have port dat_i, input, DATA_INP_WD, the beat data, with byte 0 = dat_i[7:0] processed first.
REQ-012 The block SHALL have port num_i, input, log2(BYTE_NUM) (minimum 1), giving valid bytes minus 1 on the last beat; it is ignored on other beats (all bytes valid).
REQ-013 The block SHALL have ports val_o (output, 1, result valid), rdy_i (input, 1, result consumed), dat_o (output, DATA_OUT_WD, right-aligned result with bits >= W zero) and err_o (output, 1, one-cycle protocol-error pulse).

Function
REQ-014 The block SHALL latch all cfg_* inputs on the accepted flg_fst_i beat and use the latched copy for the whole frame, including output formatting.
REQ-015 The block SHALL implement the FSM IDLE -> BUSY (accepted fst beat without lst) -> DONE (accepted lst beat) -> IDLE (val_o&&rdy_i); an accepted fst&&lst beat SHALL go IDLE -> DONE directly.
REQ-016 The block SHALL drive rdy_o = 1 in IDLE and BUSY and 0 in DONE.
REQ-017 The block SHALL process each accepted beat's valid bytes MSB-first per byte (after optional per-byte reflection), fully in one cycle, with register start = init.
REQ-018 The block SHALL assert val_o in the cycle after the last beat is accepted (latency 1) and hold val_o and dat_o stable until rdy_i.
REQ-019 The block SHALL compute dat_o = (refout ? reflect_W(crc) : crc) ^ xorout, masked to W bits.
REQ-020 In IDLE, an accepted beat without flg_fst_i SHALL be dropped with err_o pulsed and the state left in IDLE.
REQ-021 In BUSY, an accepted beat with flg_fst_i SHALL abort the current frame, start a new one from init with new cfg, and pulse err_o.
REQ-022 The block SHALL process a final beat with num_i = n as exactly n+1 bytes from byte 0 and ignore the upper bytes.
REQ-023 Configuration changes on cfg_* mid-frame SHALL have no effect until the next fst beat.

Reset
REQ-024 When rst is high at a clk edge, the block SHALL go to IDLE with val_o=0, err_o=0, dat_o=0, rdy_o=1 in the following cycle, discarding any partial frame or pending result.
REQ-025 The block SHALL give rst priority over all other inputs in the same cycle.

Verification
REQ-026 Verification SHALL drive CRC-32 (W=32, poly 04C11DB7, init FFFFFFFF, refin=refout=1, xorout FFFFFFFF) with beats 34333231, 38373635, 00000039 (num=0, lst) -> dat_o=CBF43926 one cycle after the last beat.
REQ-027 Verification SHALL drive CRC-16/CCITT-FALSE (W=16, poly 1021, init FFFF, no reflection, xorout 0) with "123456789" -> dat_o=000029B1; and CRC-8 (poly 07, init 0) -> 000000F4.
REQ-028 Verification SHALL hold rdy_i=0 for 5 cycles after val_o -> val_o and dat_o stable, rdy_o=0, offered beats not accepted; then rdy_i=1 -> IDLE next cycle.
REQ-029 Verification SHALL check protocol errors: a non-fst beat in IDLE -> err_o pulse and no state change; an fst beat mid-frame -> err_o pulse and a result equal to the CRC of the new frame only.
REQ-030 Verification SHALL assert rst mid-frame and while in DONE -> the REQ-024 values, and a following clean frame gives the correct CRC.
